// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } muldiv_state_e;

    localparam logic [MULDIV_XLEN-1:0] DIV0_QUOT  = '1;
    localparam logic [MULDIV_XLEN-1:0] SIGNED_MIN = 32'h8000_0000;

    // DIV and REM treat their operands as two's complement
    function automatic logic op_is_signed_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - issue/result bundle between execute stage and muldiv sequencer
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic                   start;
    muldiv_op_e             op;
    logic [MULDIV_XLEN-1:0] op_a;
    logic [MULDIV_XLEN-1:0] op_b;
    logic                   kill;
    logic                   busy;
    logic                   done;
    logic [MULDIV_XLEN-1:0] result;

    // execute stage side
    modport master (
        output start, op, op_a, op_b, kill,
        input  busy, done, result
    );

    // sequencer side
    modport slave (
        input  start, op, op_a, op_b, kill,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - unsigned restoring divider, one quotient bit per step
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quot_next,
    output logic [XLEN-1:0] rem_next
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   trial;

    // quot_q starts as the dividend; its MSB feeds the remainder while quotient bits fill from the LSB
    always_comb begin
        trial = {rem_q, quot_q[XLEN-1]} - {1'b0, dsr_q};
        if (!trial[XLEN]) begin
            rem_next  = trial[XLEN-1:0];
            quot_next = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next  = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
            quot_next = {quot_q[XLEN-2:0], 1'b0};
        end
    end

    assign last = (cnt_q == '0);

    // load primes the operands; each step retires one quotient bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            dsr_q  <= '0;
        end else if (load) begin
            cnt_q  <= CW'(XLEN - 1);
            rem_q  <= '0;
            quot_q <= dividend;
            dsr_q  <= divisor;
        end else if (step) begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M multiply/divide sequencer
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);

    muldiv_state_e state_q;
    muldiv_state_e state_d;

    muldiv_op_e      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] result_q;
    logic            neg_quot_q;
    logic            neg_rem_q;

    logic            accept;
    logic            in_is_div;
    logic            in_signed;
    logic            in_special;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    logic            div_load;
    logic            div_step;
    logic            div_last;
    logic [XLEN-1:0] quot_next;
    logic [XLEN-1:0] rem_next;

    logic signed [XLEN:0]     a_ext;
    logic signed [XLEN:0]     b_ext;
    logic        [2*XLEN-1:0] prod;
    logic        [XLEN-1:0]   mul_res;
    logic        [XLEN-1:0]   div_res;

    // issue decode on the incoming request; special divides take the short MUL-path timing
    always_comb begin
        accept     = bus.start && !bus.kill && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        in_is_div  = bus.op[2];
        in_signed  = op_is_signed_div(bus.op);
        in_special = in_is_div &&
                     ((bus.op_b == '0) ||
                      (in_signed && (bus.op_a == SIGNED_MIN) && (bus.op_b == '1)));
        mag_a      = (in_signed && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
        mag_b      = (in_signed && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and divider handshake; kill outranks start and in-flight work
    always_comb begin
        state_d  = state_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (in_is_div && !in_special) begin
                        state_d  = ST_DIV;
                        div_load = 1'b1;
                    end else begin
                        state_d  = ST_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                state_d = bus.kill ? ST_IDLE : ST_DONE;
            end
            ST_DIV: begin
                if (bus.kill) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (div_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // 33x33 signed product; only the low 64 bits are ever selected
    always_comb begin
        a_ext = {((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[XLEN-1], a_q};
        b_ext = {(op_q == OP_MULH) && b_q[XLEN-1], b_q};
        prod  = a_ext * b_ext;
        case (op_q)
            OP_MUL:                       mul_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: mul_res = prod[2*XLEN-1:XLEN];
            default: begin
                // only special divides reach here: divide by zero or signed overflow
                if (b_q == '0) begin
                    mul_res = op_q[1] ? a_q : DIV0_QUOT;
                end else begin
                    mul_res = op_q[1] ? '0 : SIGNED_MIN;
                end
            end
        endcase
    end

    // sign fixup on the final divider step
    always_comb begin
        if (op_q[1]) begin
            div_res = neg_rem_q ? -rem_next : rem_next;
        end else begin
            div_res = neg_quot_q ? -quot_next : quot_next;
        end
    end

    // operand latch on accept; result written only when an op completes unkilled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= OP_MUL;
            a_q        <= '0;
            b_q        <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                op_q       <= bus.op;
                a_q        <= bus.op_a;
                b_q        <= bus.op_b;
                neg_quot_q <= in_signed && (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
                neg_rem_q  <= in_signed && bus.op_a[XLEN-1];
            end
            if ((state_q == ST_MUL) && !bus.kill) begin
                result_q <= mul_res;
            end else if ((state_q == ST_DIV) && !bus.kill && div_last) begin
                result_q <= div_res;
            end
        end
    end

    muldiv_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .last      (div_last),
        .quot_next (quot_next),
        .rem_next  (rem_next)
    );

    assign bus.busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide group. It takes these operations off the single-cycle ALU path.
- Execute-stage issue: on start, the block latches the operands and the op. Multiplies complete in one iteration; divides and remainders run a 32-step restoring divider.
- Result is returned with a one-cycle done pulse. busy stalls the pipeline front end while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; the divider iterates XLEN steps.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  issue request, sampled on the clk edge
op  in  3  RV32M funct3 (same as alu_ctrl[2:0] for alu_ctrl 1xxx)
op_a  in  XLEN  rs1 value
op_b  in  XLEN  rs2 value
kill  in  1  synchronous flush; aborts the in-flight op
busy  out  1  high while an op is computing; pipeline stall
done  out  1  one-cycle pulse, result valid
result  out  XLEN  result; holds its last value until the next done

Behaviour:
- Reset: rst_n=0 at an edge forces state IDLE, busy=0, done=0, result=0, step counter=0. Reset mid-operation discards the op.
- States:
  - IDLE
  - MUL
  - DIV
  - DONE
- busy = (state==MUL || state==DIV). done = (state==DONE). Both decode from registered state.
- Accept: start=1 at an edge while state is IDLE or DONE latches op/op_a/op_b. start while busy=1 is ignored, with no queueing.
- Op map, where the quotient/remainder sign follows the RISC-V rules:
  - 000 MUL: low 32 bits of the product
  - 001 MULH: signed x signed, high 32 bits
  - 010 MULHSU: signed x unsigned, high 32 bits
  - 011 MULHU: unsigned x unsigned, high 32 bits
  - 100 DIV: signed quotient
  - 101 DIVU: unsigned quotient
  - 110 REM: signed remainder, sign of dividend
  - 111 REMU: unsigned remainder
- MUL path:
  - Accept edge goes to MUL. At the next edge the 33x33 signed product (operands sign- or zero-extended per op) is computed, the selected half is registered into result, and state goes to DONE.
  - done is high in the 2nd cycle after acceptance.
- DIV special cases resolve on the MUL-path timing (state MUL, latency 2):
  - op_b==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - Signed overflow (op_a==0x80000000, op_b==0xFFFFFFFF, DIV/REM): DIV -> 0x80000000; REM -> 0.
- DIV normal path:
  - Accept edge goes to DIV, counter=XLEN-1. Magnitudes |a| and |b| are latched for signed ops, plus the negate flags.
  - Each DIV edge does one restoring step: shift the remainder left by 1 bit, bring in the next dividend bit, subtract the divisor if non-negative, and shift the quotient bit in.
  - When counter==0 the edge applies the sign fixup, writes result, and goes to DONE.
  - done is high in the 33rd cycle after acceptance (32 step edges + DONE).
  - Quotient is negated iff the operand signs differ; remainder is negated iff the dividend is negative.
- DONE lasts exactly one cycle, then IDLE unless start is accepted the same edge.
- kill=1 at an edge in MUL or DIV goes to IDLE with result unchanged and no done pulse. kill in DONE suppresses nothing, since done is already visible. kill in IDLE has no effect. kill together with start: kill wins and nothing is accepted.
- rst_n has priority over kill, and kill over start.

Decomposition:
- muldiv_pkg holds:
  - op enum muldiv_op_e (MUL..REMU with the funct3 encodings above)
  - state enum muldiv_state_e
  - constants DIV0_QUOT='1 and SIGNED_MIN=32'h8000_0000
- One sub-module, muldiv_div_core, holds the remainder/quotient registers, the step counter and the single restoring-step datapath. It has a load/step/last handshake with the muldiv_seq FSM.
- Multiplier and special-case detect stay in muldiv_seq.

Test Plan:
- Issue MULHU then MULH then MULHSU:
  - MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> result 0xFFFFFFFE, done in 2nd cycle.
  - MULH same operands -> 0x00000000.
  - MULHSU same operands -> 0xFFFFFFFF.
  - MUL a=7 b=6 -> 42.
- DIV a=0xFFFFFFF9(-7) b=2 -> 0xFFFFFFFD after exactly 33 cycles, busy high for 32. REM same operands -> 0xFFFFFFFF. DIVU a=100 b=7 -> 14. REMU same operands -> 2.
- Divide by zero: DIV a=5 b=0 -> 0xFFFFFFFF; REMU a=5 b=0 -> 5; both with latency 2.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Kill and reset:
  - Start DIV, assert kill on cycle 10 -> IDLE next cycle, no done, result keeps the prior value.
  - rst_n=0 mid-DIV -> busy=0, result=0.
- Back-to-back issue:
  - start held through busy -> the second request is ignored until DONE.
  - start during DONE is accepted -> a new MUL gives done 2 cycles later, with no IDLE gap.
